// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, op type, arbiter state type and the
// combinational ALU evaluation used on the granted request.
package alu_pkg;

   typedef logic [2:0] alu_op_t;

   localparam alu_op_t ALU_ADD = 3'b000;
   localparam alu_op_t ALU_SUB = 3'b001;
   localparam alu_op_t ALU_AND = 3'b010;
   localparam alu_op_t ALU_OR  = 3'b011;
   localparam alu_op_t ALU_XOR = 3'b100;
   localparam alu_op_t ALU_NOT = 3'b101;
   localparam alu_op_t ALU_SHL = 3'b110;
   localparam alu_op_t ALU_SHR = 3'b111;

   typedef enum logic {
      StEmpty = 1'b0,
      StFull  = 1'b1
   } arb_state_t;

   // Returns {carry, data}. Carry is only meaningful for subtract (borrow).
   function automatic logic [4:0] alu_eval(input logic [3:0] a,
                                           input logic [3:0] b,
                                           input alu_op_t    op);
      logic [4:0] r;
      r = '0;
      case (op)
         ALU_ADD: r = {1'b0, a + b};
         // 5-bit two's complement difference: bit 4 set exactly when a < b.
         ALU_SUB: r = {1'b0, a} - {1'b0, b};
         ALU_AND: r = {1'b0, a & b};
         ALU_OR:  r = {1'b0, a | b};
         ALU_XOR: r = {1'b0, a ^ b};
         ALU_NOT: r = {1'b0, ~a};
         ALU_SHL: r = {1'b0, a[2:0], 1'b0};
         ALU_SHR: r = {2'b00, a[3:1]};
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin selector: picks the first set request at or after i_ptr,
// wrapping to 0, and reports it as a one-hot vector plus binary index.
module rr_picker #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   input  logic             i_en,
   output logic [N-1:0]     o_grant,
   output logic [IDX_W-1:0] o_idx
);

   logic             w_found;
   logic [IDX_W-1:0] w_pos;

   // Scan N positions starting at the pointer; the first hit wins.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_pos   = '0;
      for (int k = 0; k < N; k++) begin
         w_pos = IDX_W'((int'(i_ptr) + k) % N);
         if (i_en && !w_found && i_req[w_pos]) begin
            o_grant[w_pos] = 1'b1;
            o_idx          = w_pos;
            w_found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 4-bit ALU between NUM_REQ requesters. A round-robin grant feeds
// the ALU; the result is held in a tagged output register until consumed.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [4*NUM_REQ-1:0] req_a,
   input  logic [4*NUM_REQ-1:0] req_b,
   input  logic [3*NUM_REQ-1:0] req_op,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [3:0]           rsp_data,
   output logic                 rsp_carry,
   output logic [ID_W-1:0]      rsp_id
);

   arb_state_t        r_state, w_state_nxt;
   logic [ID_W-1:0]   r_ptr, w_ptr_nxt;
   logic [3:0]        r_data, w_data_nxt;
   logic              r_carry, w_carry_nxt;
   logic [ID_W-1:0]   r_id, w_id_nxt;

   logic              w_can_accept;
   logic              w_pick_en;
   logic [NUM_REQ-1:0] w_grant;
   logic [ID_W-1:0]   w_idx;
   logic              w_any;
   logic [3:0]        w_a, w_b;
   alu_op_t           w_op;
   logic [4:0]        w_alu;

   // The register can take a new result when empty or when it drains this cycle.
   assign w_can_accept = (r_state == StEmpty) || rsp_ready;
   // No grant while reset is held, so no requester believes it was accepted.
   assign w_pick_en    = w_can_accept && !rst;

   rr_picker #(
      .N     (NUM_REQ),
      .IDX_W (ID_W)
   ) u_picker (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .i_en    (w_pick_en),
      .o_grant (w_grant),
      .o_idx   (w_idx)
   );

   assign w_any     = |w_grant;
   assign req_ready = w_grant;

   // Operand mux driven by the one-hot grant.
   always_comb begin
      w_a  = '0;
      w_b  = '0;
      w_op = ALU_ADD;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant[i]) begin
            w_a  = req_a[4*i +: 4];
            w_b  = req_b[4*i +: 4];
            w_op = req_op[3*i +: 3];
         end
      end
   end

   assign w_alu = alu_eval(w_a, w_b, w_op);

   // Next-state: a grant always (re)loads the register, otherwise a consume empties it.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_data_nxt  = r_data;
      w_carry_nxt = r_carry;
      w_id_nxt    = r_id;
      if (w_any) begin
         w_state_nxt = StFull;
         w_data_nxt  = w_alu[3:0];
         w_carry_nxt = w_alu[4];
         w_id_nxt    = w_idx;
         w_ptr_nxt   = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
      end else if ((r_state == StFull) && rsp_ready) begin
         w_state_nxt = StEmpty;
      end
   end

   // State, pointer and result register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StEmpty;
         r_ptr   <= '0;
         r_data  <= '0;
         r_carry <= 1'b0;
         r_id    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_data  <= w_data_nxt;
         r_carry <= w_carry_nxt;
         r_id    <= w_id_nxt;
      end
   end

   assign rsp_valid = (r_state == StFull);
   assign rsp_data  = r_data;
   assign rsp_carry = r_carry;
   assign rsp_id    = r_id;

endmodule
